// File: rtl/fir_result_drain.sv
// Drains DATA_NUM FIR results from the result RAM onto a valid/ready stream with last flag.
// Optional FIR_DRAIN_CHECKSUM_EN adds a 32-bit sum of the drained samples on checksum_o.
module fir_result_drain #(
    parameter int DATA_NUM   = 65536,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  mem_rd_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_din_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           checksum_o,
    output logic [1:0]            dbg_state
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] NUM      = CNT_W'(DATA_NUM);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_NUM - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic                  start_d;
    logic                  start_edge;
    logic [CNT_W-1:0]      rd_cnt;
    logic [CNT_W-1:0]      out_cnt;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] fifo_mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            fifo_cnt;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  final_hs;
    logic [2:0]            credit;

    // Stream handshake: a sample transfers in any cycle where m_valid_o and m_ready_i
    // are both high; m_valid_o and m_data_o never change while waiting for m_ready_i.
    assign start_edge = start_i & ~start_d;
    assign m_valid_o  = (fifo_cnt != 2'd0);
    assign m_data_o   = fifo_mem[rd_ptr];
    assign pop        = m_valid_o & m_ready_i;
    assign push       = inflight;
    assign m_last_o   = m_valid_o & (out_cnt == LAST_IDX);
    assign final_hs   = pop & m_last_o;

    // Slots already spoken for once this cycle's pop leaves; the read issued now lands
    // in the FIFO two cycles later, so at most one may be outstanding beyond the FIFO.
    assign credit      = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign issue       = (state == S_RUN) && (rd_cnt < NUM) && (credit < 3'd2);
    assign mem_rd_en_o = issue;
    assign mem_addr_o  = rd_cnt[ADDR_WIDTH-1:0];
    assign busy_o      = (state != S_IDLE);
    assign done_o      = (state == S_DONE);
    assign dbg_state   = state;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_edge) state_nxt = S_RUN;
            S_RUN:   if (final_hs) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            start_d     <= 1'b0;
            rd_cnt      <= '0;
            out_cnt     <= '0;
            inflight    <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            fifo_cnt    <= 2'd0;
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
        end else begin
            state    <= state_nxt;
            start_d  <= start_i;
            inflight <= issue;
            fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
            if (issue) rd_cnt <= rd_cnt + CNT_W'(1);
            if (pop) begin
                out_cnt <= out_cnt + CNT_W'(1);
                rd_ptr  <= ~rd_ptr;
            end
            if (push) begin
                fifo_mem[wr_ptr] <= mem_din_i;
                wr_ptr           <= ~wr_ptr;
            end
            if (state == S_DONE) begin
                rd_cnt  <= '0;
                out_cnt <= '0;
            end
        end
    end

`ifdef FIR_DRAIN_CHECKSUM_EN
    logic [31:0] acc;

    // The last sample is folded in directly so checksum_o lands together with done_o.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc        <= 32'h0;
            checksum_o <= 32'h0;
        end else begin
            if (state == S_IDLE && start_edge) acc <= 32'h0;
            else if (pop) acc <= acc + 32'(m_data_o);
            if (final_hs) checksum_o <= acc + 32'(m_data_o);
        end
    end
`else
    assign checksum_o = 32'h0;
`endif

endmodule

// File: tb/tb_fir_result_drain.sv
// Scoreboard bench for fir_result_drain: RAM model, expected-sample queue, decoupled monitor.
module tb_fir_result_drain;

    localparam int DN = 8;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          mem_rd_en_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_din_i;
    logic [DW-1:0] m_data_o;
    logic          m_valid_o;
    logic          m_ready_i;
    logic          m_last_o;
    logic          busy_o;
    logic          done_o;
    logic [31:0]   checksum_o;
    logic [1:0]    dbg_state;

    fir_result_drain #(.DATA_NUM(DN), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .mem_rd_en_o(mem_rd_en_o),
        .mem_addr_o (mem_addr_o),
        .mem_din_i  (mem_din_i),
        .m_data_o   (m_data_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .m_last_o   (m_last_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .checksum_o (checksum_o),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- RAM model (1-cycle read latency, junk when not read) ----------------
    logic [DW-1:0] ram [16];
    always @(posedge clk) begin
        if (mem_rd_en_o) mem_din_i <= ram[mem_addr_o];
        else             mem_din_i <= DW'($urandom);
    end

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW:0]   exp_q[$];
    logic [31:0]   exp_sum;
    int            run_id = 0;
    int            t0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int          seen_id = 0;
    int          rd_num, rd_first, rd_last, valid_first, last_cyc, hs_cnt;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          issued = 0;
    int          popped = 0;
    logic        hold_pending = 1'b0;
    logic [DW:0] held;
    logic        last_hs_prev = 1'b0;
    logic [DW:0] exp_v;

    always @(negedge clk) begin
        if (run_id != seen_id) begin
            seen_id     = run_id;
            rd_num      = 0;
            rd_first    = -1;
            rd_last     = -1;
            valid_first = -1;
            last_cyc    = -1;
            hs_cnt      = 0;
        end
        if (rst) begin
            hold_pending = 1'b0;
            last_hs_prev = 1'b0;
            issued       = 0;
            popped       = 0;
        end else begin
            if (hold_pending) begin
                check("hold_valid", m_valid_o, 1);
                check("hold_data", {m_last_o, m_data_o}, held);
            end
            check("done_pulse", done_o, last_hs_prev);
            if (!m_valid_o) check("last_without_valid", m_last_o, 0);
            if (mem_rd_en_o) begin
                issued++;
                rd_num++;
                if (rd_first < 0) rd_first = cyc;
                rd_last = cyc;
            end
            if (m_valid_o && valid_first < 0) valid_first = cyc;
            last_hs_prev = 1'b0;
            if (m_valid_o && m_ready_i) begin
                popped++;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sample: got %0h required no sample (cycle %0d)", m_data_o, cyc);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("sample", {m_last_o, m_data_o}, exp_v);
                end
                if (m_last_o) begin
                    last_hs_prev = 1'b1;
                    last_cyc     = cyc;
                end
            end
            check("fifo_bound", 64'((issued - popped) <= 2), 1);
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
`ifdef FIR_DRAIN_CHECKSUM_EN
                check("checksum", checksum_o, exp_sum);
`else
                check("checksum", checksum_o, 0);
`endif
            end
            hold_pending = m_valid_o && !m_ready_i;
            held         = {m_last_o, m_data_o};
        end
    end

    // ---------------- driver tasks ----------------
    // mode 0: ready high, 1: toggle, 2: random, 3: unchanged
    task automatic step(input int mode);
        @(posedge clk);
        #1;
        case (mode)
            0: m_ready_i = 1'b1;
            1: m_ready_i = ~m_ready_i;
            2: m_ready_i = 1'($urandom_range(0, 1));
            default: ;
        endcase
    endtask

    task automatic load_and_start(input bit seq);
        logic [31:0] sum;
        sum = 32'h0;
        for (int i = 0; i < DN; i++) begin
            ram[i] = seq ? DW'(i + 1) : DW'($urandom);
            sum    = sum + 32'(ram[i]);
            exp_q.push_back({(i == DN - 1), ram[i]});
        end
        exp_sum = sum;
        run_id++;
        start_i = 1'b1;
        t0      = cyc;
    endtask

    task automatic wait_done(input int mode, input string name);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < 200) begin
            step(mode);
            k++;
        end
        n_checks++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL %s_timeout: got done count %0d required %0d", name, done_cnt, d0 + 1);
        end
        check({name, "_queue_drained"}, 64'(exp_q.size()), 0);
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, m_valid_o, 0);
        check({name, "_rd_en"}, mem_rd_en_o, 0);
        check({name, "_addr"}, mem_addr_o, 0);
        check({name, "_data"}, m_data_o, 0);
        check({name, "_last"}, m_last_o, 0);
        check({name, "_busy"}, busy_o, 0);
        check({name, "_done"}, done_o, 0);
        check({name, "_checksum"}, checksum_o, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int d;
        int k;
        rst       = 1'b1;
        start_i   = 1'b0;
        m_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) ram[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(3);

        // Case 1: full-rate drain, exact latency
        m_ready_i = 1'b1;
        load_and_start(1);
        wait_done(0, "t1");
        check("t1_first_rd", 64'(rd_first), 64'(t0 + 1));
        check("t1_last_rd", 64'(rd_last), 64'(t0 + DN));
        check("t1_rd_count", 64'(rd_num), DN);
        check("t1_first_valid", 64'(valid_first), 64'(t0 + 3));
        check("t1_last_cycle", 64'(last_cyc), 64'(t0 + DN + 2));
        check("t1_done_cycle", 64'(done_cyc), 64'(t0 + DN + 3));

        // Case 2: toggling ready
        start_i = 1'b0;
        step(0);
        load_and_start(1);
        wait_done(1, "t2");

        // Case 3: long stall right after start
        start_i = 1'b0;
        step(0);
        m_ready_i = 1'b0;
        load_and_start(1);
        repeat (20) step(3);
        @(negedge clk);
        check("t3_reads_while_stalled", 64'(rd_num), 2);
        check("t3_valid", m_valid_o, 1);
        check("t3_head", m_data_o, ram[0]);
        wait_done(0, "t3");
        check("t3_total_reads", 64'(rd_num), DN);

        // Case 4: start held high after done must not retrigger
        d = done_cnt;
        run_id++;
        repeat (50) step(0);
        check("t4_no_reads_held", 64'(rd_num), 0);
        check("t4_no_done_held", 64'(done_cnt), 64'(d));
        check("t4_idle_held", busy_o, 0);
        start_i = 1'b0;
        step(0);
        load_and_start(0);
        wait_done(0, "t4");
        repeat (20) step(0);
        check("t4_one_extra_run", 64'(done_cnt), 64'(d + 1));

        // Case 5: reset after 4 accepted samples, then replay
        start_i = 1'b0;
        step(0);
        load_and_start(1);
        k = 0;
        while (hs_cnt < 4 && k < 50) begin
            step(0);
            k++;
        end
        check("t5_reached_4", 64'(hs_cnt >= 4), 1);
        d   = done_cnt;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_idle("t5_abort");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        start_i = 1'b0;
        step(0);
        check("t5_no_done", 64'(done_cnt), 64'(d));
        load_and_start(1);
        wait_done(0, "t5_replay");

        // Case 6: random data, random back-pressure
        for (int r = 0; r < 4; r++) begin
            start_i = 1'b0;
            step(2);
            load_and_start(0);
            wait_done(2, "t6");
        end

        start_i = 1'b0;
        repeat (3) step(0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got no end of test by cycle %0d required finish", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
